uart_rx_host_ctrl: RTL and testbench

//  Host-side controller for the UART receive engine (start detect/bit-time sequencer + 10-bit shift reg).

---
 rtl/uart_pkg.sv | 42 ++++
 rtl/uart_rx_fifo.sv | 59 +++++
 rtl/uart_rx_host_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_uart_rx_host_ctrl.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the UART receive host controller.
//   rx_state_e   holding-register FSM encodings
//   STAT_*       bit positions inside the status byte
//   CFG_*        field positions inside the config byte
//   baud_count() baud_sel -> clock cycles per bit at a given clock rate
package uart_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_FULL  = 2'b01
  } rx_state_e;

  localparam int STAT_RXRDY = 0;
  localparam int STAT_PERR  = 1;
  localparam int STAT_FERR  = 2;
  localparam int STAT_OVF   = 3;

  localparam int CFG_OHEL    = 7;
  localparam int CFG_PEN     = 6;
  localparam int CFG_BIT8    = 5;
  localparam int CFG_SEL_MSB = 3;
  localparam int CFG_SEL_LSB = 0;

  // Each arm divides two constants, so this folds to a lookup table.
  function automatic logic [19:0] baud_count(input logic [3:0] sel, input int clk_hz);
    case (sel)
      4'd0:    baud_count = 20'(clk_hz / 300);
      4'd1:    baud_count = 20'(clk_hz / 1200);
      4'd2:    baud_count = 20'(clk_hz / 2400);
      4'd3:    baud_count = 20'(clk_hz / 4800);
      4'd4:    baud_count = 20'(clk_hz / 9600);
      4'd5:    baud_count = 20'(clk_hz / 19200);
      4'd6:    baud_count = 20'(clk_hz / 38400);
      4'd7:    baud_count = 20'(clk_hz / 57600);
      4'd9:    baud_count = 20'(clk_hz / 230400);
      4'd10:   baud_count = 20'(clk_hz / 460800);
      4'd11:   baud_count = 20'(clk_hz / 921600);
      default: baud_count = 20'(clk_hz / 115200);
    endcase
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 4-entry x 10-bit synchronous FIFO holding {perr, ferr, data}.
// Only instantiated when UART_RX_FIFO_EN is defined.
//   clk, reset   clock, asynchronous active-high reset
//   push, din    write strobe and entry; accepted when not full, or when full with a pop
//   pop          read strobe; ignored when empty
//   dout         head entry
//   full, empty  occupancy flags
module uart_rx_fifo (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  logic       pop,
  input  logic [9:0] din,
  output logic [9:0] dout,
  output logic       full,
  output logic       empty
);

  logic [9:0] mem_q [4];
  logic [9:0] mem_d [4];
  logic [1:0] wr_q, wr_d, rd_q, rd_d;
  logic [2:0] cnt_q, cnt_d;
  logic       do_push, do_pop;

  assign full  = (cnt_q == 3'd4);
  assign empty = (cnt_q == 3'd0);
  assign dout  = mem_q[rd_q];

  always_comb begin
    do_pop  = pop & ~empty;
    do_push = push & (~full | do_pop);
    mem_d   = mem_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    cnt_d   = cnt_q;
    if (do_push) begin
      mem_d[wr_q] = din;
      wr_d        = wr_q + 2'd1;
    end
    if (do_pop) rd_d = rd_q + 2'd1;
    if (do_push && !do_pop)      cnt_d = cnt_q + 3'd1;
    else if (do_pop && !do_push) cnt_d = cnt_q - 3'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) mem_q[i] <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_rx_host_ctrl.sv
// uart_rx_host_ctrl: host side of the UART receiver. Holds receive config,
// captures completed frames from the engine shift register, checks parity and
// stop bit, and presents data/status to the host bus with an RXRDY handshake.
//   clk, reset        clock, asynchronous active-high reset
//   cfg_we, cfg_din   config write {ohel, pen, bit8, -, baud_sel[3:0]}
//   rd_data, rd_stat  host read strobes (pop data / clear error flags)
//   rx_done, rx_sr    engine frame-complete level and shift register
//   baud, bit8, pen   decoded config to engine
//   rx_abort          one-cycle engine reset on config write
//   rx_data, status   held byte and {4'b0, ovf, ferr, perr, rxrdy}
//   rx_int            one-cycle pulse per accepted frame
// Build option: UART_RX_FIFO_EN replaces the holding register with a 4-deep FIFO.
//
//   state    | meaning
//   ST_EMPTY | no byte waiting for the host
//   ST_FULL  | byte held, rxrdy asserted
module uart_rx_host_ctrl
  import uart_pkg::*;
#(
  parameter int         CLK_HZ  = 100_000_000,
  parameter logic [7:0] CFG_RST = 8'h08
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cfg_we,
  input  logic [7:0]  cfg_din,
  input  logic        rd_data,
  input  logic        rd_stat,
  input  logic        rx_done,
  input  logic [9:0]  rx_sr,
  output logic [19:0] baud,
  output logic        bit8,
  output logic        pen,
  output logic        rx_abort,
  output logic [7:0]  rx_data,
  output logic [7:0]  status,
  output logic        rx_int
);

  logic [19:0] baud_q, baud_d;
  logic        ohel_q, ohel_d, pen_q, pen_d, bit8_q, bit8_d;
  logic        abort_q, rx_done_q, rx_int_q;
  logic        perr_q, perr_d, ferr_q, ferr_d, ovf_q, ovf_d;
  logic        unused_cfg_bit;

  logic        evt, push, ovf_set;
  logic [1:0]  sh;
  logic [3:0]  idx_p, idx_s;
  logic [9:0]  f;
  logic [7:0]  new_data;
  logic        new_perr, new_ferr;
  logic        rxrdy_w, perr_show, ferr_show;
  logic [7:0]  rx_data_w;

  assign unused_cfg_bit = cfg_din[4];
  assign evt = rx_done & ~rx_done_q;

  // Post-start bits sit at the top of rx_sr; shift them down so the first
  // data bit lands at f[0] whatever the frame length.
  always_comb begin
    sh       = 2'd2 - {1'b0, bit8_q} - {1'b0, pen_q};
    f        = rx_sr >> sh;
    idx_p    = 4'd6 + {3'b0, bit8_q} + {3'b0, pen_q};
    idx_s    = idx_p + 4'd1;
    new_data = bit8_q ? f[7:0] : {1'b0, f[6:0]};
    new_perr = pen_q & ((^new_data ^ f[idx_p]) != ohel_q);
    new_ferr = ~f[idx_s];
  end

  always_comb begin
    ohel_d = ohel_q;
    pen_d  = pen_q;
    bit8_d = bit8_q;
    baud_d = baud_q;
    if (cfg_we) begin
      ohel_d = cfg_din[CFG_OHEL];
      pen_d  = cfg_din[CFG_PEN];
      bit8_d = cfg_din[CFG_BIT8];
      baud_d = baud_count(cfg_din[CFG_SEL_MSB:CFG_SEL_LSB], CLK_HZ);
    end
  end

`ifdef UART_RX_FIFO_EN
  logic       pop, fifo_full, fifo_empty;
  logic [9:0] head;

  assign pop     = rd_data & ~fifo_empty;
  assign push    = evt & (~fifo_full | pop);
  assign ovf_set = evt & fifo_full & ~pop;

  uart_rx_fifo u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   ({new_perr, new_ferr, new_data}),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign rxrdy_w   = ~fifo_empty;
  assign rx_data_w = head[7:0];
  assign perr_show = perr_q | (~fifo_empty & head[9]);
  assign ferr_show = ferr_q | (~fifo_empty & head[8]);
`else
  rx_state_e  state_q, state_d;
  logic [7:0] data_q, data_d;

  // A read in the same cycle as a frame frees the register for that frame.
  assign push    = evt & ((state_q == ST_EMPTY) | rd_data);
  assign ovf_set = evt & (state_q == ST_FULL) & ~rd_data;

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    if (push) begin
      state_d = ST_FULL;
      data_d  = new_data;
    end else if (rd_data && state_q == ST_FULL) begin
      state_d = ST_EMPTY;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_EMPTY;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
    end
  end

  assign rxrdy_w   = (state_q == ST_FULL);
  assign rx_data_w = data_q;
  assign perr_show = perr_q;
  assign ferr_show = ferr_q;
`endif

  // A new error in the same cycle as rd_stat survives the clear.
  always_comb begin
    perr_d = (perr_q & ~rd_stat) | (push & new_perr);
    ferr_d = (ferr_q & ~rd_stat) | (push & new_ferr);
    ovf_d  = (ovf_q & ~rd_stat) | ovf_set;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ohel_q    <= CFG_RST[CFG_OHEL];
      pen_q     <= CFG_RST[CFG_PEN];
      bit8_q    <= CFG_RST[CFG_BIT8];
      baud_q    <= baud_count(CFG_RST[CFG_SEL_MSB:CFG_SEL_LSB], CLK_HZ);
      abort_q   <= 1'b0;
      rx_done_q <= 1'b0;
      rx_int_q  <= 1'b0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      ohel_q    <= ohel_d;
      pen_q     <= pen_d;
      bit8_q    <= bit8_d;
      baud_q    <= baud_d;
      abort_q   <= cfg_we;
      rx_done_q <= rx_done;
      rx_int_q  <= push;
      perr_q    <= perr_d;
      ferr_q    <= ferr_d;
      ovf_q     <= ovf_d;
    end
  end

  always_comb begin
    status             = '0;
    status[STAT_RXRDY] = rxrdy_w;
    status[STAT_PERR]  = perr_show;
    status[STAT_FERR]  = ferr_show;
    status[STAT_OVF]   = ovf_q;
  end

  assign baud     = baud_q;
  assign bit8     = bit8_q;
  assign pen      = pen_q;
  assign rx_abort = abort_q;
  assign rx_data  = rx_data_w;
  assign rx_int   = rx_int_q;

endmodule

// File: tb/tb_uart_rx_host_ctrl.sv
module tb_uart_rx_host_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cfg_we = 1'b0;
  logic [7:0]  cfg_din = '0;
  logic        rd_data = 1'b0;
  logic        rd_stat = 1'b0;
  logic        rx_done = 1'b0;
  logic [9:0]  rx_sr = '0;
  logic [19:0] baud;
  logic        bit8, pen, rx_abort, rx_int;
  logic [7:0]  rx_data, status;

  int n_checks = 0;
  int n_errors = 0;

  uart_rx_host_ctrl dut (
    .clk      (clk),
    .reset    (reset),
    .cfg_we   (cfg_we),
    .cfg_din  (cfg_din),
    .rd_data  (rd_data),
    .rd_stat  (rd_stat),
    .rx_done  (rx_done),
    .rx_sr    (rx_sr),
    .baud     (baud),
    .bit8     (bit8),
    .pen      (pen),
    .rx_abort (rx_abort),
    .rx_data  (rx_data),
    .status   (status),
    .rx_int   (rx_int)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [7:0] v);
    cfg_din = v;
    cfg_we  = 1'b1;
    tick();
    cfg_we  = 1'b0;
  endtask

  // Raise rx_done; after return the edge has been registered by the DUT.
  task automatic frame_edge(input logic [9:0] sr);
    rx_sr   = sr;
    rx_done = 1'b1;
    tick();
  endtask

  task automatic frame_release();
    rx_done = 1'b0;
    tick();
  endtask

  task automatic read_data();
    rd_data = 1'b1;
    tick();
    rd_data = 1'b0;
  endtask

  task automatic read_stat();
    rd_stat = 1'b1;
    tick();
    rd_stat = 1'b0;
  endtask

  initial begin
    // reset state: CFG_RST 8'h08 -> 115200 (868 cycles), 7N1
    tick();
    tick();
    check("rst_data", rx_data, 8'h00);
    check("rst_status", status, 8'h00);
    check("rst_int", rx_int, 1'b0);
    check("rst_abort", rx_abort, 1'b0);
    check("rst_baud", baud, 20'd868);
    check("rst_bit8", bit8, 1'b0);
    check("rst_pen", pen, 1'b0);
    reset = 1'b0;
    tick();

    // config write: 8E1 at 115200
    cfg_write(8'h68);
    check("cfg68_abort", rx_abort, 1'b1);
    check("cfg68_baud", baud, 20'd868);
    check("cfg68_bit8", bit8, 1'b1);
    check("cfg68_pen", pen, 1'b1);
    tick();
    check("cfg68_abort_end", rx_abort, 1'b0);
    cfg_write(8'h64);
    check("cfg64_baud", baud, 20'd10416);
    cfg_write(8'h20);
    check("cfg20_baud", baud, 20'd333333);

    // 8N1: n=9, frame in rx_sr[9:1] = {stop, data}
    cfg_write(8'h28);
    frame_edge({1'b1, 8'h41, 1'b0});
    check("8n1_int", rx_int, 1'b1);
    check("8n1_data", rx_data, 8'h41);
    check("8n1_status", status, 8'h01);
    tick();
    check("8n1_int_held", rx_int, 1'b0);
    frame_release();
    check("8n1_int_once", rx_int, 1'b0);
    read_data();
    check("8n1_rd_status", status, 8'h00);
    check("8n1_rd_keep", rx_data, 8'h41);
    read_data();
    check("empty_rd_ignored", status, 8'h00);

    // 8 even parity, parity bit wrong for 8'h41
    cfg_write(8'h68);
    frame_edge({1'b1, 1'b1, 8'h41});
    check("8e1_data", rx_data, 8'h41);
    check("8e1_perr", status, 8'h03);
    frame_release();
    read_stat();
    check("8e1_stat_clr", status, 8'h01);
    read_data();
    check("8e1_empty", status, 8'h00);
    // good parity: 8'h41 has two ones, even parity bit 0
    frame_edge({1'b1, 1'b0, 8'h41});
    check("8e1_good", status, 8'h01);
    frame_release();
    read_data();
    // error arriving with rd_stat stays set
    rd_stat = 1'b1;
    frame_edge({1'b1, 1'b1, 8'h41});
    rd_stat = 1'b0;
    check("perr_wins_stat", status, 8'h03);
    frame_release();
    read_stat();
    read_data();
    check("perr_cleared", status, 8'h00);

    // 7N1 with stop bit 0
    cfg_write(8'h08);
    frame_edge({1'b0, 7'h55, 2'b00});
    check("7n1_data", rx_data, 8'h55);
    check("7n1_ferr", status, 8'h05);
    frame_release();
    read_stat();
    read_data();
    // 7-bit data forces bit7 to 0
    frame_edge({1'b1, 7'h7f, 2'b11});
    check("7n1_bit7", rx_data, 8'h7f);
    check("7n1_ok", status, 8'h01);
    frame_release();
    read_data();

    // overflow: second frame dropped
    cfg_write(8'h28);
    frame_edge({1'b1, 8'h12, 1'b0});
    frame_release();
    frame_edge({1'b1, 8'h34, 1'b0});
    check("ovf_no_int", rx_int, 1'b0);
    check("ovf_data", rx_data, 8'h12);
    check("ovf_status", status, 8'h09);
    frame_release();
    read_stat();
    check("ovf_clr", status, 8'h01);
    read_data();

    // read coincident with second frame edge
    frame_edge({1'b1, 8'h21, 1'b0});
    frame_release();
    rd_data = 1'b1;
    frame_edge({1'b1, 8'h43, 1'b0});
    rd_data = 1'b0;
    check("coin_int", rx_int, 1'b1);
    check("coin_data", rx_data, 8'h43);
    check("coin_status", status, 8'h01);
    frame_release();

    // config write while holding keeps byte and flags
    cfg_write(8'h68);
    check("cfg_full_abort", rx_abort, 1'b1);
    check("cfg_full_data", rx_data, 8'h43);
    check("cfg_full_status", status, 8'h01);

    // asynchronous reset mid-hold
    #2;
    reset = 1'b1;
    #1;
    check("arst_data", rx_data, 8'h00);
    check("arst_status", status, 8'h00);
    check("arst_bit8", bit8, 1'b0);
    check("arst_pen", pen, 1'b0);
    tick();
    reset = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
